gesture_frame_sequencer: RTL and testbench
==========================================

GESTURE_FRAME_SEQUENCER -- requirements
Module: gesture_frame_sequencer

Interface
REQ-001 Parameter IMAGE_WIDTH, default 120, columns per frame (1..255).
REQ-002 Parameter IMAGE_HEIGHT, default 160, rows per frame (1..255).
REQ-003 Parameter PALM_TIMEOUT, default 255, max cycles to wait for palm_done.
REQ-004 clk  in  1  single clock; all logic on posedge clk.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 frame_ready  in  1  one-cycle pulse: frame buffer holds a complete new frame.
REQ-007 fb_rd_en / fb_row / fb_col  out  1/8/8  frame-buffer read strobe and raster address.
REQ-008 palm_clr / palm_en  out  1/1  palm-detector clear pulse and pixel-qualify enable.
REQ-009 palm_done / palm_width  in  1/8  palm detector finished; width 0 = no palm.
REQ-010 finger_clr / finger_en  out  1/1  finger-identification clear pulse and pixel-qualify enable.
REQ-011 finger_status  in  5  {thumb,index,middle,ring,pinky}, MSB = thumb.
REQ-012 gesture_valid / gesture_ready  out/in  1/1  result handshake.
REQ-013 gesture_fingers / gesture_count / no_hand  out  5/3/1  latched statuses, popcount 0..5, no-palm flag.
REQ-014 busy / overrun_cnt  out  1/8  state != IDLE; saturating count of dropped frame_ready pulses.

Function
REQ-015 FSM states SHALL be IDLE, PALM_CLR, PALM_SCAN, PALM_WAIT, FING_CLR, FING_SCAN, SETTLE, REPORT.
REQ-016 IDLE -> PALM_CLR on frame_ready; palm_clr SHALL be high for exactly the PALM_CLR cycle.
REQ-017 In PALM_SCAN and FING_SCAN, fb_rd_en SHALL be 1 every cycle, raster col-fastest from (0,0) to (IMAGE_HEIGHT-1, IMAGE_WIDTH-1).
REQ-018 fb_col SHALL wrap to 0 at IMAGE_WIDTH-1 with fb_row +1; after the last address, fb_row/fb_col SHALL return to 0 and the state SHALL advance.
REQ-019 palm_en/finger_en SHALL equal fb_rd_en of the respective scan delayed one cycle (1-cycle buffer read latency); exactly W*H enable cycles per scan.
REQ-020 PALM_WAIT: on palm_done with palm_width != 0 -> FING_CLR; with palm_width == 0 -> REPORT, no_hand=1, gesture_fingers=0.
REQ-021 PALM_WAIT SHALL count cycles; reaching PALM_TIMEOUT without palm_done -> REPORT with no_hand=1.
REQ-022 palm_done arriving in the same cycle as the last palm_en SHALL be accepted on entry to PALM_WAIT (sampled in PALM_WAIT's first cycle).
REQ-023 finger_clr SHALL be high for exactly the FING_CLR cycle, then FING_SCAN starts.
REQ-024 SETTLE SHALL last 2 cycles after the last finger_en, then latch finger_status into gesture_fingers and its popcount into gesture_count, no_hand=0.
REQ-025 REPORT: gesture_valid=1, outputs stable until gesture_valid && gesture_ready, then IDLE next cycle.
REQ-026 frame_ready while busy (including the REPORT-accept cycle) SHALL be dropped and overrun_cnt +1, saturating at 255.
REQ-027 gesture_ready asserted outside REPORT SHALL have no effect.

Reset
REQ-028 rst SHALL force IDLE in the next cycle from any state, including mid-scan.
REQ-029 Reset values: all strobes/enables 0, fb_row=fb_col=0, gesture_valid=0, gesture_fingers=0, gesture_count=0, no_hand=0, busy=0, overrun_cnt=0, timeout counter 0.
REQ-030 frame_ready coincident with rst SHALL be ignored.

Structure
REQ-031 State encoding, finger bit positions and default image dimensions SHALL live in shared package gesture_pkg.
REQ-032 Raster counter SHALL be sub-module raster_addr_gen (start, W/H inputs, row/col, last, enable); FSM remains in the top module.

Verification
REQ-033 W=4,H=3, frame_ready, palm_done with width 20 at 5 cycles, finger_status=5'b01110 -> each enable high 12 cycles, gesture_fingers=01110, count=3, no_hand=0.
REQ-034 palm_done with palm_width=0 -> no FING_CLR/finger_en, REPORT with no_hand=1, fingers=0, count=0.
REQ-035 palm_done never asserted, PALM_TIMEOUT=10 -> REPORT exactly 10 cycles after entering PALM_WAIT, no_hand=1.
REQ-036 gesture_ready held low 50 cycles in REPORT -> outputs stable 50 cycles; 3 frame_ready pulses meanwhile -> overrun_cnt=3; 300 pulses -> 255.
REQ-037 rst at row 1 col 2 of FING_SCAN -> next cycle IDLE, all outputs at reset values; next frame_ready runs a full correct sequence.
REQ-038 Default 120x160, all fingers 1 -> scan length 19200 cycles per pass, count=5.

Source files
------------

// File: rtl/gesture_pkg.sv
// gesture_pkg: shared FSM state encoding, finger bit positions and default image size
// for the gesture frame sequencer.
package gesture_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PALM_CLR,
        PALM_SCAN,
        PALM_WAIT,
        FING_CLR,
        FING_SCAN,
        SETTLE,
        REPORT
    } state_t;

    localparam int DEF_IMAGE_WIDTH  = 120;
    localparam int DEF_IMAGE_HEIGHT = 160;

    localparam int FINGER_THUMB  = 4;
    localparam int FINGER_INDEX  = 3;
    localparam int FINGER_MIDDLE = 2;
    localparam int FINGER_RING   = 1;
    localparam int FINGER_PINKY  = 0;

    function automatic logic [2:0] finger_count(input logic [4:0] f);
        return {2'b0, f[FINGER_THUMB]} + {2'b0, f[FINGER_INDEX]} + {2'b0, f[FINGER_MIDDLE]}
             + {2'b0, f[FINGER_RING]} + {2'b0, f[FINGER_PINKY]};
    endfunction

endpackage

// File: rtl/raster_addr_gen.sv
// raster_addr_gen: column-fastest raster address counter over a width x height image.
// Ports: clk/rst; start zeroes the address; enable advances it; width/height set the
// image size; row/col are the current address; last flags the final address, after
// which an enabled step wraps back to (0,0).
module raster_addr_gen (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       enable,
    input  logic [7:0] width,
    input  logic [7:0] height,
    output logic [7:0] row,
    output logic [7:0] col,
    output logic       last
);

    logic col_end;

    assign col_end = col == width - 8'd1;
    assign last    = col_end && row == height - 8'd1;

    always_ff @(posedge clk) begin
        if (rst || start) begin
            row <= '0;
            col <= '0;
        end else if (enable) begin
            col <= col_end ? 8'd0 : col + 8'd1;
            row <= last ? 8'd0 : (col_end ? row + 8'd1 : row);
        end
    end

endmodule

// File: rtl/gesture_frame_sequencer.sv
// gesture_frame_sequencer: per-frame control of palm detection then finger identification.
// Ports: frame_ready starts a frame; fb_rd_en/fb_row/fb_col read the frame buffer;
// palm_clr/palm_en and finger_clr/finger_en drive the two detectors; palm_done/palm_width
// and finger_status are their results; gesture_valid/gesture_ready hand off the latched
// gesture_fingers/gesture_count/no_hand; busy and overrun_cnt report occupancy and drops.
module gesture_frame_sequencer
    import gesture_pkg::*;
#(
    parameter int IMAGE_WIDTH  = DEF_IMAGE_WIDTH,
    parameter int IMAGE_HEIGHT = DEF_IMAGE_HEIGHT,
    parameter int PALM_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_ready,
    output logic       fb_rd_en,
    output logic [7:0] fb_row,
    output logic [7:0] fb_col,
    output logic       palm_clr,
    output logic       palm_en,
    input  logic       palm_done,
    input  logic [7:0] palm_width,
    output logic       finger_clr,
    output logic       finger_en,
    input  logic [4:0] finger_status,
    output logic       gesture_valid,
    input  logic       gesture_ready,
    output logic [4:0] gesture_fingers,
    output logic [2:0] gesture_count,
    output logic       no_hand,
    output logic       busy,
    output logic [7:0] overrun_cnt
);

    localparam logic [7:0]  W8      = 8'(IMAGE_WIDTH);
    localparam logic [7:0]  H8      = 8'(IMAGE_HEIGHT);
    localparam logic [15:0] TO_LAST = 16'(PALM_TIMEOUT - 1);

    state_t      state, next_state;
    logic [15:0] wait_cnt;
    logic [1:0]  settle_cnt;
    logic        last;

    assign busy          = state != IDLE;
    assign fb_rd_en      = state == PALM_SCAN || state == FING_SCAN;
    assign palm_clr      = state == PALM_CLR;
    assign finger_clr    = state == FING_CLR;
    assign gesture_valid = state == REPORT;

    raster_addr_gen u_raster (
        .clk    (clk),
        .rst    (rst),
        .start  (palm_clr || finger_clr),
        .enable (fb_rd_en),
        .width  (W8),
        .height (H8),
        .row    (fb_row),
        .col    (fb_col),
        .last   (last)
    );

    always_comb begin
        next_state = state;
        case (state)
            IDLE:      next_state = frame_ready ? PALM_CLR : IDLE;
            PALM_CLR:  next_state = PALM_SCAN;
            PALM_SCAN: next_state = last ? PALM_WAIT : PALM_SCAN;
            // palm_done is sampled from the first wait cycle, so a result coinciding
            // with the final palm_en is not lost.
            PALM_WAIT: next_state = palm_done ? (palm_width != 8'd0 ? FING_CLR : REPORT)
                                  : (wait_cnt == TO_LAST ? REPORT : PALM_WAIT);
            FING_CLR:  next_state = FING_SCAN;
            FING_SCAN: next_state = last ? SETTLE : FING_SCAN;
            // SETTLE spans the last finger_en cycle plus two more for the detector to settle.
            SETTLE:    next_state = settle_cnt == 2'd2 ? REPORT : SETTLE;
            REPORT:    next_state = gesture_ready ? IDLE : REPORT;
            default:   next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            palm_en         <= 1'b0;
            finger_en       <= 1'b0;
            wait_cnt        <= '0;
            settle_cnt      <= '0;
            gesture_fingers <= '0;
            gesture_count   <= '0;
            no_hand         <= 1'b0;
            overrun_cnt     <= '0;
        end else begin
            state      <= next_state;
            palm_en    <= state == PALM_SCAN;
            finger_en  <= state == FING_SCAN;
            wait_cnt   <= state == PALM_WAIT ? wait_cnt + 16'd1 : 16'd0;
            settle_cnt <= state == SETTLE ? settle_cnt + 2'd1 : 2'd0;
            if (busy && frame_ready && overrun_cnt != 8'hff)
                overrun_cnt <= overrun_cnt + 8'd1;
            if (state == PALM_WAIT && next_state == REPORT) begin
                gesture_fingers <= '0;
                gesture_count   <= '0;
                no_hand         <= 1'b1;
            end
            if (state == SETTLE && next_state == REPORT) begin
                gesture_fingers <= finger_status;
                gesture_count   <= finger_count(finger_status);
                no_hand         <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_gesture_frame_sequencer.sv
// tb_gesture_frame_sequencer: directed plus randomized frames against a behavioural model.
module tb_gesture_frame_sequencer;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int N  = W * H;
    localparam int DW = 120;
    localparam int DN = 120 * 160;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       s_frame_ready, s_fb_rd_en, s_palm_clr, s_palm_en, s_palm_done;
    logic       s_finger_clr, s_finger_en, s_gesture_valid, s_gesture_ready, s_no_hand, s_busy;
    logic [7:0] s_fb_row, s_fb_col, s_palm_width, s_overrun_cnt;
    logic [4:0] s_finger_status, s_gesture_fingers;
    logic [2:0] s_gesture_count;

    logic       d_frame_ready, d_fb_rd_en, d_palm_clr, d_palm_en, d_palm_done;
    logic       d_finger_clr, d_finger_en, d_gesture_valid, d_gesture_ready, d_no_hand, d_busy;
    logic [7:0] d_fb_row, d_fb_col, d_palm_width, d_overrun_cnt;
    logic [4:0] d_finger_status, d_gesture_fingers;
    logic [2:0] d_gesture_count;

    gesture_frame_sequencer #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .PALM_TIMEOUT(10)) dut_s (
        .clk(clk), .rst(rst), .frame_ready(s_frame_ready),
        .fb_rd_en(s_fb_rd_en), .fb_row(s_fb_row), .fb_col(s_fb_col),
        .palm_clr(s_palm_clr), .palm_en(s_palm_en), .palm_done(s_palm_done), .palm_width(s_palm_width),
        .finger_clr(s_finger_clr), .finger_en(s_finger_en), .finger_status(s_finger_status),
        .gesture_valid(s_gesture_valid), .gesture_ready(s_gesture_ready),
        .gesture_fingers(s_gesture_fingers), .gesture_count(s_gesture_count), .no_hand(s_no_hand),
        .busy(s_busy), .overrun_cnt(s_overrun_cnt)
    );

    gesture_frame_sequencer dut_d (
        .clk(clk), .rst(rst), .frame_ready(d_frame_ready),
        .fb_rd_en(d_fb_rd_en), .fb_row(d_fb_row), .fb_col(d_fb_col),
        .palm_clr(d_palm_clr), .palm_en(d_palm_en), .palm_done(d_palm_done), .palm_width(d_palm_width),
        .finger_clr(d_finger_clr), .finger_en(d_finger_en), .finger_status(d_finger_status),
        .gesture_valid(d_gesture_valid), .gesture_ready(d_gesture_ready),
        .gesture_fingers(d_gesture_fingers), .gesture_count(d_gesture_count), .no_hand(d_no_hand),
        .busy(d_busy), .overrun_cnt(d_overrun_cnt)
    );

    int n_cmp = 0, n_bad = 0, ov = 0, cyc = 0;
    int sidx = 0, didx = 0;
    logic prev_rd = 1'b0, prev_drd = 1'b0, prev_valid = 1'b0;
    int cnt_pc = 0, cnt_pe = 0, cnt_fc = 0, cnt_fe = 0, last_pe = 0, last_fe = 0, valid_rise = 0;
    int b_pc = 0, b_pe = 0, b_fc = 0, b_fe = 0;
    int d_rd_n = 0, d_pe_n = 0, d_fe_n = 0, bd_rd = 0, bd_pe = 0, bd_fe = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle and update the reference model of raster order, enable
    // latency and per-frame event counts.
    task automatic tick();
        @(negedge clk);
        #1;
        cyc++;
        if (rst) begin
            sidx = 0; didx = 0; prev_rd = 1'b0; prev_drd = 1'b0; prev_valid = 1'b0;
        end else begin
            if (s_fb_rd_en) begin
                chk("raster_row", s_fb_row, sidx / W);
                chk("raster_col", s_fb_col, sidx % W);
                sidx = (sidx + 1) % N;
            end
            chk("en_latency", s_palm_en | s_finger_en, prev_rd);
            prev_rd = s_fb_rd_en;
            if (d_fb_rd_en) begin
                chk("d_raster_row", d_fb_row, didx / DW);
                chk("d_raster_col", d_fb_col, didx % DW);
                didx = (didx + 1) % DN;
            end
            chk("d_en_latency", d_palm_en | d_finger_en, prev_drd);
            prev_drd = d_fb_rd_en;
            cnt_pc += int'(s_palm_clr);
            cnt_pe += int'(s_palm_en);
            cnt_fc += int'(s_finger_clr);
            cnt_fe += int'(s_finger_en);
            if (s_palm_en) last_pe = cyc;
            if (s_finger_en) last_fe = cyc;
            if (s_gesture_valid && !prev_valid) valid_rise = cyc;
            prev_valid = s_gesture_valid;
            d_rd_n += int'(d_fb_rd_en);
            d_pe_n += int'(d_palm_en);
            d_fe_n += int'(d_finger_en);
        end
    endtask

    function automatic bit cond(input int w);
        case (w)
            0:       return cnt_pe - b_pe == N;
            1:       return s_gesture_valid === 1'b1;
            2:       return d_pe_n - bd_pe == DN;
            3:       return d_gesture_valid === 1'b1;
            default: return cnt_fc - b_fc == 1 && s_fb_rd_en === 1'b1 && s_fb_row === 8'd1 && s_fb_col === 8'd2;
        endcase
    endfunction

    task automatic wait_for(input int w, input int lim, input string tag);
        int i = 0;
        while (!cond(w) && i < lim) begin
            tick();
            i++;
        end
        chk(tag, cond(w), 1);
    endtask

    task automatic chk_reset();
        chk("rst_rd_en", s_fb_rd_en, 0);
        chk("rst_row", s_fb_row, 0);
        chk("rst_col", s_fb_col, 0);
        chk("rst_strobes", {s_palm_clr, s_palm_en, s_finger_clr, s_finger_en}, 0);
        chk("rst_valid", s_gesture_valid, 0);
        chk("rst_fingers", s_gesture_fingers, 0);
        chk("rst_count", s_gesture_count, 0);
        chk("rst_no_hand", s_no_hand, 0);
        chk("rst_busy", s_busy, 0);
        chk("rst_overrun", s_overrun_cnt, 0);
    endtask

    task automatic start_frame();
        b_pc = cnt_pc; b_pe = cnt_pe; b_fc = cnt_fc; b_fe = cnt_fe;
        s_frame_ready   = 1'b1;
        s_gesture_ready = 1'($urandom_range(0, 1));
        tick();
        s_frame_ready = 1'b0;
    endtask

    function automatic int sat(input int v);
        return v < 255 ? v + 1 : 255;
    endfunction

    // mode 0: palm found, 1: palm width zero, 2: palm_done never arrives
    task automatic run_small(input int mode, input int d, input logic [4:0] fing,
                             input int hold, input int pulses, input bit acc_fr);
        logic [4:0] ef;
        logic [2:0] ec;
        s_finger_status = fing;
        start_frame();
        wait_for(0, 100, "palm_scan_done");
        s_gesture_ready = 1'b0;
        chk("scan_end_addr", {s_fb_rd_en, s_fb_row, s_fb_col}, 0);
        if (mode < 2) begin
            repeat (d) tick();
            s_palm_done  = 1'b1;
            s_palm_width = mode == 0 ? 8'($urandom_range(1, 255)) : 8'd0;
            tick();
            s_palm_done = 1'b0;
        end
        wait_for(1, 200, "report_reached");
        ef = mode == 0 ? fing : 5'd0;
        ec = mode == 0 ? 3'($countones(fing)) : 3'd0;
        chk("palm_clr_cycles", cnt_pc - b_pc, 1);
        chk("palm_en_cycles", cnt_pe - b_pe, N);
        chk("finger_clr_cycles", cnt_fc - b_fc, mode == 0 ? 1 : 0);
        chk("finger_en_cycles", cnt_fe - b_fe, mode == 0 ? N : 0);
        if (mode == 0) chk("settle_gap", valid_rise - last_fe, 3);
        else chk("palm_wait_gap", valid_rise - last_pe, mode == 1 ? d + 1 : 10);
        for (int i = 0; i < hold; i++) begin
            chk("hold_valid", s_gesture_valid, 1);
            chk("hold_fingers", s_gesture_fingers, ef);
            chk("hold_count", s_gesture_count, ec);
            chk("hold_no_hand", s_no_hand, mode != 0);
            chk("hold_busy", s_busy, 1);
            s_frame_ready = i < 2 * pulses && i % 2 == 0;
            if (s_frame_ready) ov = sat(ov);
            tick();
        end
        s_gesture_ready = 1'b1;
        s_frame_ready   = acc_fr;
        if (acc_fr) ov = sat(ov);
        tick();
        s_gesture_ready = 1'b0;
        s_frame_ready   = 1'b0;
        chk("accept_valid", s_gesture_valid, 0);
        chk("accept_busy", s_busy, 0);
        chk("overrun_cnt", s_overrun_cnt, ov);
        tick();
        chk("idle_after_drop", s_busy, 0);
    endtask

    initial begin
        s_frame_ready = 1'b1; s_palm_done = 1'b0; s_palm_width = 8'd0;
        s_finger_status = 5'd0; s_gesture_ready = 1'b0;
        d_frame_ready = 1'b0; d_palm_done = 1'b0; d_palm_width = 8'd0;
        d_finger_status = 5'h1f; d_gesture_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        s_frame_ready = 1'b0;
        chk_reset();
        tick();
        chk("rst_frame_ignored", s_busy, 0);

        run_small(0, 5, 5'b01110, 50, 3, 1'b0);
        run_small(1, 3, 5'b11111, 4, 0, 1'b1);
        run_small(2, 0, 5'b10000, 5, 1, 1'b0);
        run_small(0, 0, 5'b00001, 600, 300, 1'b1);
        for (int k = 0; k < 6; k++) begin
            int h;
            h = $urandom_range(1, 10);
            run_small($urandom_range(0, 2), $urandom_range(0, 8), 5'($urandom_range(0, 31)),
                      h, $urandom_range(0, h / 2), 1'($urandom_range(0, 1)));
        end

        s_finger_status = 5'b11000;
        start_frame();
        wait_for(0, 100, "rs_palm_scan_done");
        s_gesture_ready = 1'b0;
        s_palm_done  = 1'b1;
        s_palm_width = 8'd7;
        tick();
        s_palm_done = 1'b0;
        wait_for(4, 50, "rs_reach_row1_col2");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ov = 0;
        chk_reset();
        tick();
        chk("rs_idle", s_busy, 0);
        run_small(0, 2, 5'b10101, 3, 1, 1'b0);

        bd_rd = d_rd_n; bd_pe = d_pe_n; bd_fe = d_fe_n;
        d_frame_ready = 1'b1;
        tick();
        d_frame_ready = 1'b0;
        wait_for(2, 20000, "d_palm_scan_done");
        d_palm_done  = 1'b1;
        d_palm_width = 8'd50;
        tick();
        d_palm_done = 1'b0;
        wait_for(3, 20000, "d_report_reached");
        chk("d_rd_cycles", d_rd_n - bd_rd, 2 * DN);
        chk("d_palm_en_cycles", d_pe_n - bd_pe, DN);
        chk("d_finger_en_cycles", d_fe_n - bd_fe, DN);
        chk("d_fingers", d_gesture_fingers, 5'h1f);
        chk("d_count", d_gesture_count, 5);
        chk("d_no_hand", d_no_hand, 0);
        d_gesture_ready = 1'b1;
        tick();
        d_gesture_ready = 1'b0;
        chk("d_accept_valid", d_gesture_valid, 0);
        chk("d_overrun", d_overrun_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
